// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the 8-bit pipelined core ISA: opcode values,
// instruction field bit positions, the decoded control bundle, the ID/EX
// pipeline register layout and its bubble value.
// Optional feature macro used by decode_stage: WB_BYPASS_EN.
// -----------------------------------------------------------------------------
package isa_pkg;

   // Opcodes
   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LD   = 4'd7;
   localparam logic [3:0] OP_ST   = 4'd8;
   localparam logic [3:0] OP_BEQ  = 4'd9;

   // Instruction field bit positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   typedef struct packed {
      logic alusrc;
      logic memread;
      logic memwrite;
      logic regwrite;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   typedef struct packed {
      logic       valid;
      logic [3:0] opcode;
      logic [2:0] destreg;
      logic [7:0] op1;
      logic [7:0] op2;
      logic [7:0] imm;
      ctrl_t      ctrl;
   } idex_t;

   // A bubble clears every field, operands and immediate included.
   localparam idex_t IDEX_BUBBLE = '0;

   function automatic logic [7:0] sext6(input logic [5:0] v);
      return {{2{v[5]}}, v};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Bundles every non-clock/reset signal of the decode stage: fetch-side
// instruction and flush, register-file read/writeback ports, EX-stage load
// info, stall back to fetch and the ID/EX register outputs.
//   master : environment side (fetch, regfile, EX) - drives the stage inputs
//   slave  : decode_stage side
// -----------------------------------------------------------------------------
interface decode_stage_if;
   logic        if_valid;
   logic [15:0] if_instr;
   logic        flush;
   logic [2:0]  srcreg1;
   logic [2:0]  srcreg2;
   logic [7:0]  rdata1;
   logic [7:0]  rdata2;
   logic        wb_write;
   logic [2:0]  wb_destreg;
   logic [7:0]  wb_data;
   logic        ex_memread;
   logic [2:0]  ex_destreg;
   logic        stall;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [2:0]  id_destreg;
   logic [7:0]  id_op1;
   logic [7:0]  id_op2;
   logic [7:0]  id_imm;
   logic        id_alusrc;
   logic        id_memread;
   logic        id_memwrite;
   logic        id_regwrite;
   logic        id_branch;

   modport master (
      output if_valid, if_instr, flush, rdata1, rdata2,
             wb_write, wb_destreg, wb_data, ex_memread, ex_destreg,
      input  srcreg1, srcreg2, stall,
             id_valid, id_opcode, id_destreg, id_op1, id_op2, id_imm,
             id_alusrc, id_memread, id_memwrite, id_regwrite, id_branch
   );

   modport slave (
      input  if_valid, if_instr, flush, rdata1, rdata2,
             wb_write, wb_destreg, wb_data, ex_memread, ex_destreg,
      output srcreg1, srcreg2, stall,
             id_valid, id_opcode, id_destreg, id_op1, id_op2, id_imm,
             id_alusrc, id_memread, id_memwrite, id_regwrite, id_branch
   );
endinterface

// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl
// Purely combinational opcode decoder.
//   opcode_i      : instruction opcode
//   ctrl_o        : control bundle for EX/MEM/WB
//   use1_o/use2_o : instruction reads source 1 / source 2
//   src2_is_rd_o  : source 2 comes from the rd field (ST, BEQ)
// Undefined opcodes 10-15 decode like NOP.
// -----------------------------------------------------------------------------
module decode_ctrl
   import isa_pkg::*;
(
   input  logic [3:0] opcode_i,
   output ctrl_t      ctrl_o,
   output logic       use1_o,
   output logic       use2_o,
   output logic       src2_is_rd_o
);

   always_comb begin
      ctrl_o       = CTRL_NONE;
      use1_o       = 1'b0;
      use2_o       = 1'b0;
      src2_is_rd_o = 1'b0;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            ctrl_o.regwrite = 1'b1;
            use1_o          = 1'b1;
            use2_o          = 1'b1;
         end
         OP_ADDI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            use1_o          = 1'b1;
         end
         OP_LD: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.memread  = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            use1_o          = 1'b1;
         end
         OP_ST: begin
            ctrl_o.memwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            use1_o          = 1'b1;
            use2_o          = 1'b1;
            src2_is_rd_o    = 1'b1;
         end
         OP_BEQ: begin
            ctrl_o.branch = 1'b1;
            use1_o        = 1'b1;
            use2_o        = 1'b1;
            src2_is_rd_o  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Instruction-decode stage between fetch and execute. Drives the register
// file read addresses from the incoming instruction, decodes control, detects
// load-use hazards (stall to fetch, bubble to execute), honours flush and
// registers the result into the ID/EX pipeline register (1-cycle latency).
// Ports:
//   clk   : core clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : decode_stage_if.slave (fetch, regfile, writeback, EX, ID/EX outputs)
// Optional feature: define WB_BYPASS_EN to forward the writeback data into
// the captured operands when the writeback target matches a source register.
// -----------------------------------------------------------------------------
module decode_stage
   import isa_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);

   logic [3:0] opcode;
   ctrl_t      ctrl;
   logic       use1;
   logic       use2;
   logic       src2_is_rd;
   logic       hazard;
   logic [7:0] op1_sel;
   logic [7:0] op2_sel;
   idex_t      idex_d;
   idex_t      idex_q;

   assign opcode = bus.if_instr[OPC_HI:OPC_LO];

   decode_ctrl u_ctrl (
      .opcode_i     (opcode),
      .ctrl_o       (ctrl),
      .use1_o       (use1),
      .use2_o       (use2),
      .src2_is_rd_o (src2_is_rd)
   );

   // ST and BEQ read their second source from the rd field.
   assign bus.srcreg1 = bus.if_instr[RS1_HI:RS1_LO];
   assign bus.srcreg2 = src2_is_rd ? bus.if_instr[RD_HI:RD_LO]
                                   : bus.if_instr[RS2_HI:RS2_LO];

   // r0 is an ordinary register, so no zero-register exemption here.
   assign hazard = bus.if_valid & bus.ex_memread &
                   ((use1 & (bus.ex_destreg == bus.srcreg1)) |
                    (use2 & (bus.ex_destreg == bus.srcreg2)));

   // A flush discards the instruction anyway, so holding fetch is pointless.
   assign bus.stall = hazard & ~bus.flush & rst_n;

`ifdef WB_BYPASS_EN
   // The register file only updates on the edge, so forward the value being
   // written this cycle.
   assign op1_sel = (bus.wb_write && (bus.wb_destreg == bus.srcreg1)) ? bus.wb_data : bus.rdata1;
   assign op2_sel = (bus.wb_write && (bus.wb_destreg == bus.srcreg2)) ? bus.wb_data : bus.rdata2;
`else
   assign op1_sel = bus.rdata1;
   assign op2_sel = bus.rdata2;
`endif

   // Capture only a valid, unflushed, hazard-free instruction; otherwise bubble.
   always_comb begin
      idex_d = IDEX_BUBBLE;
      if (bus.if_valid && !bus.flush && !hazard) begin
         idex_d.valid   = 1'b1;
         idex_d.opcode  = opcode;
         idex_d.destreg = bus.if_instr[RD_HI:RD_LO];
         idex_d.op1     = op1_sel;
         idex_d.op2     = op2_sel;
         idex_d.imm     = sext6(bus.if_instr[IMM_HI:IMM_LO]);
         idex_d.ctrl    = ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) idex_q <= IDEX_BUBBLE;
      else        idex_q <= idex_d;
   end

   assign bus.id_valid    = idex_q.valid;
   assign bus.id_opcode   = idex_q.opcode;
   assign bus.id_destreg  = idex_q.destreg;
   assign bus.id_op1      = idex_q.op1;
   assign bus.id_op2      = idex_q.op2;
   assign bus.id_imm      = idex_q.imm;
   assign bus.id_alusrc   = idex_q.ctrl.alusrc;
   assign bus.id_memread  = idex_q.ctrl.memread;
   assign bus.id_memwrite = idex_q.ctrl.memwrite;
   assign bus.id_regwrite = idex_q.ctrl.regwrite;
   assign bus.id_branch   = idex_q.ctrl.branch;

endmodule
